de_scoreboard: RTL and testbench

DE_SCOREBOARD -- requirements
Module: de_scoreboard

---
 rtl/de_scoreboard_pkg.sv | 19 +
 rtl/de_scoreboard_sb_counter.sv | 31 +++
 rtl/de_scoreboard.sv | 102 ++++++++++
 tb/tb_de_scoreboard.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/de_scoreboard_pkg.sv
// Shared decode-stage constants for the register/CSR write scoreboard.
// Also defines the encoding used to report why decode is stalled.
package de_scoreboard_pkg;

  localparam int REGNOBITS    = 5;
  localparam int DEF_REGWORDS = 32;
  localparam int DBITS        = 32;
  localparam int DEF_CNTBITS  = 2;

  typedef enum logic [2:0] {
    STALL_NONE     = 3'd0,
    STALL_RS1      = 3'd1,
    STALL_RS2      = 3'd2,
    STALL_RD_FULL  = 3'd3,
    STALL_CSR_RD   = 3'd4,
    STALL_CSR_FULL = 3'd5
  } stall_cause_e;

endpackage

// File: rtl/de_scoreboard_sb_counter.sv
// Saturating up/down pending-write counter; simultaneous inc+dec holds the value.
// err pulses combinationally on increment-at-max or decrement-at-zero.
module sb_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         sat,
  output logic         err
);

  logic zero;

  assign sat  = &cnt;
  assign zero = (cnt == '0);
  assign err  = (inc && !dec && sat) || (dec && !inc && zero);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (inc && !dec && !sat) begin
      cnt <= cnt + W'(1);
    end else if (dec && !inc && !zero) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/de_scoreboard.sv
// Decode-stage scoreboard: tracks pending register/CSR writes and raises a
// combinational stall on RAW or counter-full hazards; WB retire is seen same-cycle.
module de_scoreboard
  import de_scoreboard_pkg::*;
#(
  parameter int REGWORDS = DEF_REGWORDS,
  parameter int CNTBITS  = DEF_CNTBITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic                 issue_wr_reg,
  input  logic [4:0]           issue_rd,
  input  logic                 issue_rs1_used,
  input  logic [4:0]           issue_rs1,
  input  logic                 issue_rs2_used,
  input  logic [4:0]           issue_rs2,
  input  logic                 issue_wr_csr,
  input  logic                 issue_rd_csr,
  input  logic                 flush,
  input  logic                 wb_wr_reg,
  input  logic [4:0]           wb_wregno,
  input  logic                 wb_wr_csr,
  output logic                 stall,
  output logic [REGWORDS-1:0]  busy_bits,
  output logic [31:0]          stall_cycles,
  output logic                 sb_error
);

  logic [CNTBITS-1:0]  cnt [REGWORDS];
  logic [REGWORDS-1:0] sat_v;
  logic [REGWORDS-1:0] err_v;
  logic [CNTBITS-1:0]  csr_cnt;
  logic                csr_sat;
  logic                csr_err;
  logic                accept;
  logic                rs1_hit, rs2_hit;
  stall_cause_e        cause;

  // A same-cycle WB to the source register clears the hazard (regfile writes on negedge).
  assign rs1_hit = wb_wr_reg && (wb_wregno == issue_rs1);
  assign rs2_hit = wb_wr_reg && (wb_wregno == issue_rs2);

  always_comb begin
    cause = STALL_NONE;
    if (issue_rs1_used && issue_rs1 != '0 && cnt[issue_rs1] > CNTBITS'(rs1_hit))
      cause = STALL_RS1;
    else if (issue_rs2_used && issue_rs2 != '0 && cnt[issue_rs2] > CNTBITS'(rs2_hit))
      cause = STALL_RS2;
    else if (issue_wr_reg && issue_rd != '0 && sat_v[issue_rd])
      cause = STALL_RD_FULL;
    else if (issue_rd_csr && csr_cnt > CNTBITS'(wb_wr_csr))
      cause = STALL_CSR_RD;
    else if (issue_wr_csr && csr_sat)
      cause = STALL_CSR_FULL;
  end

  assign stall  = reset && issue_valid && !flush && (cause != STALL_NONE);
  assign accept = issue_valid && !flush && !stall;

  for (genvar i = 0; i < REGWORDS; i++) begin : g_reg
    if (i == 0) begin : g_zero
      // x0 is hardwired; its counter never moves.
      sb_counter #(.W(CNTBITS)) u_cnt (
        .clk(clk), .reset(reset), .inc(1'b0), .dec(1'b0),
        .cnt(cnt[i]), .sat(sat_v[i]), .err(err_v[i])
      );
    end else begin : g_nz
      sb_counter #(.W(CNTBITS)) u_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (accept && issue_wr_reg && (issue_rd == REGNOBITS'(i))),
        .dec  (wb_wr_reg && (wb_wregno == REGNOBITS'(i))),
        .cnt  (cnt[i]),
        .sat  (sat_v[i]),
        .err  (err_v[i])
      );
    end
    assign busy_bits[i] = |cnt[i];
  end

  sb_counter #(.W(CNTBITS)) u_csr_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (accept && issue_wr_csr),
    .dec  (wb_wr_csr),
    .cnt  (csr_cnt),
    .sat  (csr_sat),
    .err  (csr_err)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      sb_error     <= 1'b0;
    end else begin
      if (stall) stall_cycles <= stall_cycles + 32'd1;
      if ((|err_v) || csr_err) sb_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_de_scoreboard.sv
// Directed bench for de_scoreboard; expectations queued with each step and
// checked against DUT outputs mid-cycle.
module tb_de_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_wr_reg, issue_rs1_used, issue_rs2_used;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2, wb_wregno;
  logic        issue_wr_csr, issue_rd_csr, flush, wb_wr_reg, wb_wr_csr;
  logic        stall;
  logic [31:0] busy_bits;
  logic [31:0] stall_cycles;
  logic        sb_error;

  de_scoreboard dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_wr_reg(issue_wr_reg), .issue_rd(issue_rd),
    .issue_rs1_used(issue_rs1_used), .issue_rs1(issue_rs1),
    .issue_rs2_used(issue_rs2_used), .issue_rs2(issue_rs2),
    .issue_wr_csr(issue_wr_csr), .issue_rd_csr(issue_rd_csr), .flush(flush),
    .wb_wr_reg(wb_wr_reg), .wb_wregno(wb_wregno), .wb_wr_csr(wb_wr_csr),
    .stall(stall), .busy_bits(busy_bits), .stall_cycles(stall_cycles), .sb_error(sb_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          kind;  // 0 stall, 1 busy_bits, 2 sb_error, 3 stall_cycles
    logic [31:0] val;
  } exp_t;

  exp_t expq[$];
  int   checks   = 0;
  int   failures = 0;
  int   sc_exp   = 0;

  task automatic push(input string tag, input int kind, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.kind = kind; e.val = val;
    expq.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [31:0] obs;
    while (expq.size() > 0) begin
      e = expq.pop_front();
      case (e.kind)
        0:       obs = {31'd0, stall};
        1:       obs = busy_bits;
        2:       obs = {31'd0, sb_error};
        default: obs = stall_cycles;
      endcase
      checks++;
      assert (obs === e.val)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_wr_reg = 0; issue_rd = 0;
    issue_rs1_used = 0; issue_rs1 = 0; issue_rs2_used = 0; issue_rs2 = 0;
    issue_wr_csr = 0; issue_rd_csr = 0; flush = 0;
    wb_wr_reg = 0; wb_wregno = 0; wb_wr_csr = 0;
  endtask

  task automatic issue(input logic wr, input logic [4:0] rd,
                       input logic u1, input logic [4:0] r1,
                       input logic u2, input logic [4:0] r2);
    issue_valid = 1; issue_wr_reg = wr; issue_rd = rd;
    issue_rs1_used = u1; issue_rs1 = r1; issue_rs2_used = u2; issue_rs2 = r2;
  endtask

  task automatic wb(input logic [4:0] r);
    wb_wr_reg = 1; wb_wregno = r;
  endtask

  // Inputs are already driven; check mid-cycle, then cross the edge.
  task automatic tick(input string tag, input logic es, input logic [31:0] eb, input logic ee);
    push({tag, ".stall"}, 0, {31'd0, es});
    push({tag, ".busy"}, 1, eb);
    push({tag, ".err"}, 2, {31'd0, ee});
    if (es) sc_exp++;
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 0;
    repeat (2) @(posedge clk);
    push("rst.stall", 0, 0); push("rst.busy", 1, 0);
    push("rst.err", 2, 0);   push("rst.sc", 3, 0);
    @(negedge clk); check_all();
    @(posedge clk); #1; reset = 1;

    // Back-to-back RAW on x5, resolved by same-cycle WB.
    issue(1, 5'd5, 1, 5'd0, 0, 5'd0);    tick("raw_i1", 0, 32'h0, 0);
    issue(1, 5'd6, 1, 5'd5, 1, 5'd5);    tick("raw_s1", 1, 32'h20, 0);
    issue(1, 5'd6, 1, 5'd5, 1, 5'd5);    tick("raw_s2", 1, 32'h20, 0);
    issue(1, 5'd6, 1, 5'd5, 1, 5'd5); wb(5'd5); tick("raw_wb", 0, 32'h20, 0);
    wb(5'd6);                            tick("raw_fall", 0, 32'h40, 0);
    push("raw.sc", 3, sc_exp);           tick("raw_idle", 0, 32'h0, 0);

    // Saturate x7 then hit the full-counter stall.
    issue(1, 5'd7, 0, 5'd0, 0, 5'd0);    tick("sat_w1", 0, 32'h0, 0);
    issue(1, 5'd7, 0, 5'd0, 0, 5'd0);    tick("sat_w2", 0, 32'h80, 0);
    issue(1, 5'd7, 0, 5'd0, 0, 5'd0);    tick("sat_w3", 0, 32'h80, 0);
    issue(1, 5'd7, 0, 5'd0, 0, 5'd0);    tick("sat_w4", 1, 32'h80, 0);
    wb(5'd7);                            tick("sat_d1", 0, 32'h80, 0);
    wb(5'd7);                            tick("sat_d2", 0, 32'h80, 0);
    wb(5'd7);                            tick("sat_d3", 0, 32'h80, 0);
    push("sat.sc", 3, sc_exp);           tick("sat_idle", 0, 32'h0, 0);

    // Simultaneous issue and retire of x9 leaves the count at 1.
    issue(1, 5'd9, 0, 5'd0, 0, 5'd0);    tick("same_i", 0, 32'h0, 0);
    issue(1, 5'd9, 0, 5'd0, 0, 5'd0); wb(5'd9); tick("same_iw", 0, 32'h200, 0);
    wb(5'd9);                            tick("same_hold", 0, 32'h200, 0);
    tick("same_clr", 0, 32'h0, 0);

    // Flush squashes a hazarding write to x3.
    issue(1, 5'd3, 0, 5'd0, 0, 5'd0);    tick("fl_i", 0, 32'h0, 0);
    issue(1, 5'd3, 1, 5'd3, 0, 5'd0); flush = 1; tick("fl_sq", 0, 32'h8, 0);
    wb(5'd3); push("fl.sc", 3, sc_exp);  tick("fl_wb", 0, 32'h8, 0);
    tick("fl_clr", 0, 32'h0, 0);

    // CSR read-after-write.
    issue_valid = 1; issue_wr_csr = 1;   tick("csr_w", 0, 32'h0, 0);
    issue_valid = 1; issue_rd_csr = 1;   tick("csr_rs", 1, 32'h0, 0);
    issue_valid = 1; issue_rd_csr = 1; wb_wr_csr = 1; tick("csr_wb", 0, 32'h0, 0);
    push("csr.sc", 3, sc_exp);           tick("csr_idle", 0, 32'h0, 0);

    // Underflow on x4 is sticky; x0 never becomes busy.
    wb(5'd4);                            tick("uf_wb", 0, 32'h0, 0);
    issue(1, 5'd0, 1, 5'd0, 0, 5'd0);    tick("uf_set", 0, 32'h0, 1);
    issue(1, 5'd0, 1, 5'd0, 1, 5'd0);    tick("x0_chk", 0, 32'h0, 1);
    tick("uf_hold", 0, 32'h0, 1);

    // Async reset mid-cycle with x5 and x7 pending and a live hazard.
    issue(1, 5'd5, 0, 5'd0, 0, 5'd0);    tick("ar_i5", 0, 32'h0, 1);
    issue(1, 5'd7, 0, 5'd0, 0, 5'd0);    tick("ar_i7", 0, 32'h20, 1);
    issue(0, 5'd0, 1, 5'd5, 0, 5'd0);
    push("ar_pre.stall", 0, 1); push("ar_pre.busy", 1, 32'hA0);
    @(negedge clk); check_all();
    #1 reset = 0;
    #1;
    push("ar.stall", 0, 0); push("ar.busy", 1, 0);
    push("ar.sc", 3, 0);    push("ar.err", 2, 0);
    check_all();
    @(posedge clk); #1; reset = 1;
    idle_inputs();
    sc_exp = 0;

    // First issue after reset release is accepted at the next edge.
    issue(1, 5'd5, 0, 5'd0, 0, 5'd0);    tick("post_i", 0, 32'h0, 0);
    push("post.sc", 3, sc_exp);          tick("post_busy", 0, 32'h20, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
